// File: rtl/mul_seq_pkg.sv
// Shared encodings and sizing helper for the sequential multiplier.
// Consumed by mul_int_seq_ctrl; no logic of its own.
// Not applicable.
package mul_seq_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Counter must be able to represent WIDTH itself, hence WIDTH+1.
    function automatic int cnt_w(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/adder_nbit.sv
// Unsigned WIDTH-bit adder; carry-out is dropped so the sum wraps mod 2^WIDTH.
// Latency: combinational, zero cycles.
// Backpressure: none, pure function of its inputs.
module adder_nbit #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum
);

    assign sum = a + b;

endmodule

// File: rtl/mul_int_seq_ctrl.sv
// Serial shift-add multiplier returning (A*B) mod 2^WIDTH through one shared adder.
// Latency: out_valid rises exactly WIDTH cycles after the accepting edge.
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready.
module mul_int_seq_ctrl
    import mul_seq_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] P,
    output logic             busy
);

    localparam int CNT_W = cnt_w(WIDTH);

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] p_q;
    logic [WIDTH-1:0] addend;
    logic [WIDTH-1:0] sum;
    logic             accept;
    logic             last_iter;

    assign accept    = in_valid && (state == ST_IDLE);
    assign last_iter = (state == ST_RUN) && (cnt == CNT_W'(WIDTH - 1));
    assign addend    = mplier[0] ? mcand : '0;

    adder_nbit #(.WIDTH(WIDTH)) u_adder (
        .a   (acc),
        .b   (addend),
        .sum (sum)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        state <= ST_RUN;
                        cnt   <= '0;
                    end
                end
                ST_RUN: begin
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // p_q is separate from acc so P keeps the last product while a new run clears acc.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            p_q    <= '0;
        end else if (accept) begin
            mcand  <= A;
            mplier <= B;
            acc    <= '0;
        end else if (state == ST_RUN) begin
            acc    <= sum;
            mcand  <= {mcand[WIDTH-2:0], 1'b0};
            mplier <= {1'b0, mplier[WIDTH-1:1]};
            if (last_iter) begin
                p_q <= sum;
            end
        end
    end

    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);
    assign busy      = (state == ST_RUN) || (state == ST_DONE);
    assign P         = p_q;

endmodule

// File: tb/tb_mul_int_seq_ctrl.sv
// Bench for mul_int_seq_ctrl: directed table at WIDTH=4/8, corner sequences, random scoreboard.
module tb_mul_int_seq_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic       iv4, ir4, ov4, or4, busy4;
    logic [3:0] a4, b4, p4;
    logic       iv8, ir8, ov8, or8, busy8;
    logic [7:0] a8, b8, p8;

    mul_int_seq_ctrl #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4), .A(a4), .B(b4),
        .out_valid(ov4), .out_ready(or4), .P(p4), .busy(busy4)
    );

    mul_int_seq_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .A(a8), .B(b8),
        .out_valid(ov8), .out_ready(or8), .P(p8), .busy(busy8)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        int         w;
        logic [7:0] a;
        logic [7:0] b;
        int         stall;
        logic [7:0] exp;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ir_of(input int w);
        return (w == 4) ? 32'(ir4) : 32'(ir8);
    endfunction
    function automatic logic [31:0] ov_of(input int w);
        return (w == 4) ? 32'(ov4) : 32'(ov8);
    endfunction
    function automatic logic [31:0] busy_of(input int w);
        return (w == 4) ? 32'(busy4) : 32'(busy8);
    endfunction
    function automatic logic [31:0] p_of(input int w);
        return (w == 4) ? 32'(p4) : 32'(p8);
    endfunction

    task automatic set_in(input int w, input logic v, input logic [7:0] a, input logic [7:0] b);
        if (w == 4) begin
            iv4 = v; a4 = a[3:0]; b4 = b[3:0];
        end else begin
            iv8 = v; a8 = a; b8 = b;
        end
    endtask

    task automatic set_or(input int w, input logic v);
        if (w == 4) or4 = v;
        else        or8 = v;
    endtask

    // One full transaction; called at a negedge, returns at a negedge with the DUT back in IDLE.
    task automatic txn(input int w, input logic [7:0] a, input logic [7:0] b,
                       input int stall, input logic [7:0] exp, input string tag);
        int lat;
        int guard;
        guard = 0;
        while (ir_of(w) !== 32'd1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        chk({tag, " ready"}, ir_of(w), 1);
        set_or(w, 1'b0);
        set_in(w, 1'b1, a, b);
        @(negedge clk);
        set_in(w, 1'b0, 8'($urandom), 8'($urandom));
        chk({tag, " in_ready drop"}, ir_of(w), 0);
        chk({tag, " busy"}, busy_of(w), 1);
        lat = 0;
        while (ov_of(w) !== 32'd1 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, " latency"}, 32'(lat), 32'(w));
        chk({tag, " P"}, p_of(w), 32'(exp));
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            chk({tag, " stall out_valid"}, ov_of(w), 1);
            chk({tag, " stall P"}, p_of(w), 32'(exp));
        end
        set_or(w, 1'b1);
        @(negedge clk);
        set_or(w, 1'b0);
        chk({tag, " out_valid drop"}, ov_of(w), 0);
        chk({tag, " idle in_ready"}, ir_of(w), 1);
        chk({tag, " idle busy"}, busy_of(w), 0);
    endtask

    logic [7:0]  exp_q[$];
    logic [7:0]  e;
    logic [15:0] m;
    int          sent, got, cyc, lat;
    bit          pending, stray;

    initial begin
        tbl[0] = '{4, 8'd3,   8'd5,   0, 8'd15};
        tbl[1] = '{4, 8'd7,   8'd7,   0, 8'd1};
        tbl[2] = '{8, 8'd255, 8'd255, 0, 8'd1};
        tbl[3] = '{8, 8'd0,   8'd200, 0, 8'd0};
        tbl[4] = '{8, 8'd6,   8'd9,   5, 8'd54};
        tbl[5] = '{4, 8'd15,  8'd15,  1, 8'd1};
        tbl[6] = '{8, 8'd16,  8'd16,  0, 8'd0};
        tbl[7] = '{8, 8'd13,  8'd11,  2, 8'd143};

        rst_n = 1'b0;
        set_in(4, 1'b0, 8'd0, 8'd0);
        set_in(8, 1'b0, 8'd0, 8'd0);
        or4 = 1'b0;
        or8 = 1'b0;
        #12;
        chk("reset in_ready4", 32'(ir4), 1);
        chk("reset out_valid4", 32'(ov4), 0);
        chk("reset busy8", 32'(busy8), 0);
        chk("reset P8", 32'(p8), 0);
        chk("reset out_valid8", 32'(ov8), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            txn(tbl[i].w, tbl[i].a, tbl[i].b, tbl[i].stall, tbl[i].exp, $sformatf("vec%0d", i));
        end

        // Request held through RUN with a different pair: must not disturb the running product.
        or8 = 1'b1;
        set_in(8, 1'b1, 8'd3, 8'd5);
        @(negedge clk);
        set_in(8, 1'b1, 8'd10, 8'd20);
        lat = 0;
        while (ov8 !== 1'b1 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        chk("hold first latency", 32'(lat), 8);
        chk("hold first P", 32'(p8), 15);
        @(negedge clk);
        chk("hold idle in_ready", 32'(ir8), 1);
        chk("hold idle out_valid", 32'(ov8), 0);
        @(negedge clk);
        chk("hold second accepted", 32'(ir8), 0);
        set_in(8, 1'b0, 8'd0, 8'd0);
        lat = 0;
        while (ov8 !== 1'b1 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        chk("hold second latency", 32'(lat), 8);
        chk("hold second P", 32'(p8), 200);
        @(negedge clk);
        or8 = 1'b0;
        chk("hold back idle", 32'(ir8), 1);

        // Reset while the run is at cnt=3.
        set_in(8, 1'b1, 8'd6, 8'd9);
        @(negedge clk);
        set_in(8, 1'b0, 8'd0, 8'd0);
        repeat (3) @(negedge clk);
        chk("midrun busy before reset", 32'(busy8), 1);
        rst_n = 1'b0;
        #1;
        chk("midrun reset in_ready", 32'(ir8), 1);
        chk("midrun reset out_valid", 32'(ov8), 0);
        chk("midrun reset busy", 32'(busy8), 0);
        chk("midrun reset P", 32'(p8), 0);
        @(negedge clk);
        rst_n = 1'b1;
        or8 = 1'b1;
        stray = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ov8 !== 1'b0) stray = 1'b1;
        end
        chk("midrun no stray out_valid", 32'(stray), 0);
        or8 = 1'b0;

        // Random traffic against a queue of expected products.
        sent = 0;
        got = 0;
        cyc = 0;
        pending = 1'b0;
        while (got < 1000 && cyc < 40000) begin
            @(negedge clk);
            cyc++;
            or8 = ($urandom % 3) != 0;
            if (ov8 === 1'b1 && or8) begin
                if (exp_q.size() == 0) begin
                    chk("rand unexpected result", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("rand P", 32'(p8), 32'(e));
                end
                got++;
            end
            if (!pending && sent < 1000 && ($urandom % 4) != 0) pending = 1'b1;
            iv8 = pending;
            if (pending) begin
                a8 = 8'($urandom);
                b8 = 8'($urandom);
            end
            if (pending && ir8 === 1'b1) begin
                m = 16'(a8) * 16'(b8);
                exp_q.push_back(m[7:0]);
                sent++;
                pending = 1'b0;
            end
        end
        iv8 = 1'b0;
        or8 = 1'b0;
        chk("rand results received", 32'(got), 1000);
        chk("rand queue drained", 32'(exp_q.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
